ctrl_fsm: RTL and testbench
===========================

Name: ctrl_fsm

Overview:
- Multicycle control unit for the RV32I datapath; the control-side counterpart of the datapath.
- Latches `instr`, decodes it and sequences the datapath control signals (PCSel, ImmSel, RegWen, ASel/BSel, ALU_op, MemRW, WBSel, …) through per-instruction state sequences.
- Consumes branch compare flags BrEQ/BrLT and a memory ready handshake.
- Replaces bench-driven control, so the datapath runs programs autonomously.

Parameters:
- RESET_IR, 32'h0000_0013, instruction register value after reset (NOP).
- MEM_WAIT_MAX, 15, maximum cycles MEM waits for i_mem_ready before flagging o_illegal.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-low reset
- instr  in  32  instruction from IMEM, valid in FETCH
- BrEQ  in  1  rs1==rs2 from branch comparator
- BrLT  in  1  rs1<rs2, signedness per BrUn
- i_mem_ready  in  1  LSU completes the access this cycle
- o_pc_en  out  1  PC register write enable
- PCSel  out  1  0=PC+4, 1=ALU result
- ImmSel  out  4  0000 I, 0001 S, 0010 B, 0100 J, 1000 U
- RegWen  out  1  register file write
- BrUn  out  1  unsigned compare
- ASel  out  1  0=rs1, 1=PC
- BSel  out  1  0=rs2, 1=imm
- ALU_op  out  2  00 add, 01 funct3/funct7 decode, 10 pass B
- LoadType  out  4  byte-enable mask: 0001 byte, 0011 half, 1111 word
- LoadSigned  out  1  sign-extend load data
- MemRW  out  1  1=store write
- WBSel  out  2  00 mem, 01 ALU, 10 PC+4
- LUI_Sel  out  1  LUI path select
- o_illegal  out  1  sticky fault flag
- o_state  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH: IR<=instr; → DECODE.
- DECODE: unsupported opcode → TRAP; else → EXEC.
- EXEC by class:
  - branch → FETCH
  - load/store → MEM
  - all others → WB
- MEM: holds until i_mem_ready=1.
  - load → WB; store → FETCH.
  - Wait counter hits MEM_WAIT_MAX → TRAP.
- WB → FETCH.
- Cycle counts: ALU/LUI/AUIPC/JAL/JALR 4, branch 3, store ≥4, load ≥5.
- Outputs are decoded combinationally from state, IR and flags. Every output is 0 outside its asserting state.
- Write strobes are glitch-free single-state pulses:
  - RegWen only in WB.
  - MemRW only in MEM for stores, held for the whole wait.
- o_pc_en asserted exactly once per instruction, in its final state:
  - WB, EXEC for branches, or MEM on the ready cycle for stores.
- PCSel=1 with o_pc_en when: JAL, JALR, or branch taken.
  - BEQ: BrEQ; BNE: !BrEQ; BLT/BLTU: BrLT; BGE/BGEU: !BrLT.
  - BrUn=1 for BLTU/BGEU.
- ASel=1 for branch/JAL/AUIPC; BSel=1 for every non-R-type.
- ALU_op: 00 for load/store/branch/jump address, 10 for LUI, else 01.
- WBSel=10 for JAL/JALR.
- LoadType/LoadSigned derive from funct3 during MEM and WB.
- Reset (async, any state): state=FETCH, IR=RESET_IR, counters 0, o_illegal=0, all outputs 0 combinationally. A store interrupted mid-MEM must not reassert MemRW.
- TRAP: absorbing; all strobes 0; o_illegal=1 until reset.

Optional Feature:
- CTRL_PERF_CNT_EN defined: adds outputs o_cycle[31:0] and o_instret[31:0].
  - o_cycle increments every non-reset cycle.
  - o_instret increments on each o_pc_en.
  - Both wrap at 2^32, both cleared by reset, both frozen in TRAP.
- Undefined: the ports do not exist and there is no counter logic.

Decomposition:
- Package ctrl_pkg holds:
  - state_e enum;
  - opcode localparams (LOAD 0000011, STORE 0100011, BRANCH 1100011, OP 0110011, OP_IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111);
  - ImmSel, ALU_op and WBSel encodings.
- Sub-module ctrl_decode: combinational IR→instruction-class/field decode. The FSM, wait counter and optional counters stay in ctrl_fsm.

Test Plan:
- ADDI x1,x0,10 (0x00A00093):
  - o_state 0,1,2,4.
  - In WB: RegWen=1, BSel=1, ALU_op=01, WBSel=01, o_pc_en=1.
  - RegWen low in every other cycle.
- SH x14,0(x12) then LH x15,0(x12), i_mem_ready delayed 3 cycles:
  - MemRW=1 for exactly 4 MEM cycles, LoadType=0011.
  - LH reaches WB with WBSel=00, LoadSigned=1.
- BEQ with BrEQ=1: PCSel=1, o_pc_en=1 in EXEC, 3 cycles total. BEQ with BrEQ=0: PCSel=0, o_pc_en=1.
- Illegal opcode 0x0000007F: TRAP after DECODE, o_illegal=1; no RegWen, MemRW or o_pc_en ever again; reset clears it.
- Timeout: i_mem_ready never high on a load → TRAP after 15 MEM cycles.
- Async reset mid-MEM of store: same-cycle MemRW=0, o_state=0; then a NOP (RESET_IR) sequence runs cleanly. With CTRL_PERF_CNT_EN: o_instret=10 after 10 ADDIs.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and control-field encodings for the RV32I multicycle controller
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] IMM_I = 4'b0000;
  localparam logic [3:0] IMM_S = 4'b0001;
  localparam logic [3:0] IMM_B = 4'b0010;
  localparam logic [3:0] IMM_J = 4'b0100;
  localparam logic [3:0] IMM_U = 4'b1000;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_FUNCT  = 2'b01;
  localparam logic [1:0] ALU_PASS_B = 2'b10;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // funct3[1:0] access size to byte-lane mask
  function automatic logic [3:0] byte_mask(input logic [1:0] size);
    case (size)
      2'b00:   byte_mask = 4'b0001;
      2'b01:   byte_mask = 4'b0011;
      2'b10:   byte_mask = 4'b1111;
      default: byte_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode/funct3 decode into instruction class and static datapath selects
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic       legal,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_lui,
  output logic       is_jump,
  output logic [3:0] imm_sel,
  output logic       a_sel,
  output logic       b_sel,
  output logic [1:0] alu_op,
  output logic [1:0] wb_sel,
  output logic [3:0] load_type,
  output logic       load_signed,
  output logic       br_unsigned
);

  always_comb begin
    legal     = 1'b1;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_lui    = 1'b0;
    is_jump   = 1'b0;
    imm_sel   = IMM_I;
    a_sel     = 1'b0;
    b_sel     = 1'b1;
    alu_op    = ALU_FUNCT;
    wb_sel    = WB_ALU;
    case (opcode)
      OPC_LOAD: begin
        is_load = 1'b1;
        alu_op  = ALU_ADD;
        wb_sel  = WB_MEM;
      end
      OPC_STORE: begin
        is_store = 1'b1;
        imm_sel  = IMM_S;
        alu_op   = ALU_ADD;
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        imm_sel   = IMM_B;
        a_sel     = 1'b1;
        alu_op    = ALU_ADD;
      end
      OPC_OP:     b_sel = 1'b0;
      OPC_OP_IMM: ;
      OPC_LUI: begin
        is_lui  = 1'b1;
        imm_sel = IMM_U;
        alu_op  = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        imm_sel = IMM_U;
        a_sel   = 1'b1;
      end
      OPC_JAL: begin
        is_jump = 1'b1;
        imm_sel = IMM_J;
        a_sel   = 1'b1;
        alu_op  = ALU_ADD;
        wb_sel  = WB_PC4;
      end
      OPC_JALR: begin
        is_jump = 1'b1;
        alu_op  = ALU_ADD;
        wb_sel  = WB_PC4;
      end
      default: legal = 1'b0;
    endcase
  end

  assign load_type   = (is_load | is_store) ? byte_mask(funct3[1:0]) : 4'b0000;
  assign load_signed = is_load & ~funct3[2];
  assign br_unsigned = is_branch & funct3[2] & funct3[1];

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multicycle RV32I control FSM sequencing the datapath strobes
// Optional cycle/retired-instruction counters: define CTRL_PERF_CNT_EN.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_IR     = 32'h0000_0013,
  parameter int          MEM_WAIT_MAX = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] instr,
  input  logic        BrEQ,
  input  logic        BrLT,
  input  logic        i_mem_ready,
  output logic        o_pc_en,
  output logic        PCSel,
  output logic [3:0]  ImmSel,
  output logic        RegWen,
  output logic        BrUn,
  output logic        ASel,
  output logic        BSel,
  output logic [1:0]  ALU_op,
  output logic [3:0]  LoadType,
  output logic        LoadSigned,
  output logic        MemRW,
  output logic [1:0]  WBSel,
  output logic        LUI_Sel,
  output logic        o_illegal,
  output logic [2:0]  o_state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] o_cycle,
  output logic [31:0] o_instret
`endif
);

  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_DECODE = ST_DECODE;
  localparam logic [2:0] S_EXEC   = ST_EXEC;
  localparam logic [2:0] S_MEM    = ST_MEM;
  localparam logic [2:0] S_WB     = ST_WB;
  localparam logic [2:0] S_TRAP   = ST_TRAP;

  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  logic [2:0]        state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic       dec_legal, dec_load, dec_store, dec_branch, dec_lui, dec_jump;
  logic [3:0] dec_imm_sel, dec_load_type;
  logic       dec_a_sel, dec_b_sel, dec_load_signed, dec_br_unsigned;
  logic [1:0] dec_alu_op, dec_wb_sel;
  logic       br_taken;

  ctrl_decode u_decode (
    .opcode      (ir_q[6:0]),
    .funct3      (ir_q[14:12]),
    .legal       (dec_legal),
    .is_load     (dec_load),
    .is_store    (dec_store),
    .is_branch   (dec_branch),
    .is_lui      (dec_lui),
    .is_jump     (dec_jump),
    .imm_sel     (dec_imm_sel),
    .a_sel       (dec_a_sel),
    .b_sel       (dec_b_sel),
    .alu_op      (dec_alu_op),
    .wb_sel      (dec_wb_sel),
    .load_type   (dec_load_type),
    .load_signed (dec_load_signed),
    .br_unsigned (dec_br_unsigned)
  );

  // Register fields are consumed by the datapath directly, not by control
  logic unused_ir_fields;
  assign unused_ir_fields = ^{ir_q[31:15], ir_q[11:7]};

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        wait_d = '0;
        if (dec_branch)                 state_d = S_FETCH;
        else if (dec_load || dec_store) state_d = S_MEM;
        else                            state_d = S_WB;
      end
      S_MEM: begin
        if (i_mem_ready)            state_d = dec_load ? S_WB : S_FETCH;
        else if (wait_q == WAIT_LAST) state_d = S_TRAP;
        else                        wait_d = wait_q + 1'b1;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_FETCH;
      ir_q    <= RESET_IR;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    case (ir_q[14:12])
      3'b000:         br_taken = BrEQ;
      3'b001:         br_taken = ~BrEQ;
      3'b100, 3'b110: br_taken = BrLT;
      3'b101, 3'b111: br_taken = ~BrLT;
      default:        br_taken = 1'b0;
    endcase
  end

  // Strobes are pure functions of the state, so reset or TRAP drops them at once
  always_comb begin
    o_pc_en    = 1'b0;
    PCSel      = 1'b0;
    ImmSel     = 4'b0000;
    RegWen     = 1'b0;
    BrUn       = 1'b0;
    ASel       = 1'b0;
    BSel       = 1'b0;
    ALU_op     = 2'b00;
    LoadType   = 4'b0000;
    LoadSigned = 1'b0;
    MemRW      = 1'b0;
    WBSel      = 2'b00;
    LUI_Sel    = 1'b0;
    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      ImmSel  = dec_imm_sel;
      ASel    = dec_a_sel;
      BSel    = dec_b_sel;
      ALU_op  = dec_alu_op;
      BrUn    = dec_br_unsigned;
      LUI_Sel = dec_lui;
    end
    if (state_q inside {S_MEM, S_WB}) begin
      LoadType   = dec_load_type;
      LoadSigned = dec_load_signed;
    end
    case (state_q)
      S_EXEC: begin
        if (dec_branch) begin
          o_pc_en = 1'b1;
          PCSel   = br_taken;
        end
      end
      S_MEM: begin
        MemRW   = dec_store;
        o_pc_en = dec_store & i_mem_ready;
      end
      S_WB: begin
        RegWen  = 1'b1;
        WBSel   = dec_wb_sel;
        o_pc_en = 1'b1;
        PCSel   = dec_jump;
      end
      default: ;
    endcase
  end

  assign o_illegal = (state_q == S_TRAP);
  assign o_state   = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_q, cycle_d, instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (state_q != S_TRAP) begin
      cycle_d = cycle_q + 32'd1;
      if (o_pc_en) instret_d = instret_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign o_cycle   = cycle_q;
  assign o_instret = instret_q;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - directed bench for ctrl_fsm with a per-instruction sequence model
module tb_ctrl_fsm;

  localparam int WAIT_MAX = 15;

  logic        clk;
  logic        i_reset;
  logic [31:0] instr;
  logic        BrEQ, BrLT, i_mem_ready;
  logic        o_pc_en, PCSel, RegWen, BrUn, ASel, BSel, LoadSigned, MemRW, LUI_Sel, o_illegal;
  logic [3:0]  ImmSel, LoadType;
  logic [1:0]  ALU_op, WBSel;
  logic [2:0]  o_state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] o_cycle, o_instret;
`endif

  ctrl_fsm #(.RESET_IR(32'h0000_0013), .MEM_WAIT_MAX(WAIT_MAX)) dut (
    .i_clk(clk), .i_reset(i_reset), .instr(instr), .BrEQ(BrEQ), .BrLT(BrLT),
    .i_mem_ready(i_mem_ready), .o_pc_en(o_pc_en), .PCSel(PCSel), .ImmSel(ImmSel),
    .RegWen(RegWen), .BrUn(BrUn), .ASel(ASel), .BSel(BSel), .ALU_op(ALU_op),
    .LoadType(LoadType), .LoadSigned(LoadSigned), .MemRW(MemRW), .WBSel(WBSel),
    .LUI_Sel(LUI_Sel), .o_illegal(o_illegal), .o_state(o_state)
`ifdef CTRL_PERF_CNT_EN
    , .o_cycle(o_cycle), .o_instret(o_instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_en;
    logic       pcsel;
    logic [3:0] imm;
    logic       regwen;
    logic       brun;
    logic       asel;
    logic       bsel;
    logic [1:0] aluop;
    logic [3:0] ltype;
    logic       lsigned;
    logic       memrw;
    logic [1:0] wbsel;
    logic       lui;
    logic       ill;
    logic [2:0] st;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int pcen_cnt = 0, regwen_cnt = 0, memrw_cnt = 0;

  function automatic exp_t sample();
    exp_t a;
    a.pc_en = o_pc_en;   a.pcsel = PCSel;     a.imm = ImmSel;     a.regwen = RegWen;
    a.brun = BrUn;       a.asel = ASel;       a.bsel = BSel;      a.aluop = ALU_op;
    a.ltype = LoadType;  a.lsigned = LoadSigned; a.memrw = MemRW; a.wbsel = WBSel;
    a.lui = LUI_Sel;     a.ill = o_illegal;   a.st = o_state;
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Selects that depend only on which instruction is in flight
  function automatic exp_t datapath_ctrl(input logic [31:0] ins);
    exp_t c;
    logic [6:0] opc;
    logic [2:0] f3;
    c = '0;
    opc = ins[6:0];
    f3 = ins[14:12];
    c.bsel = (opc != 7'h33);
    c.aluop = 2'b01;
    case (opc)
      7'h03: c.aluop = 2'b00;
      7'h23: begin c.imm = 4'b0001; c.aluop = 2'b00; end
      7'h63: begin c.imm = 4'b0010; c.asel = 1'b1; c.aluop = 2'b00; c.brun = (f3 == 3'd6 || f3 == 3'd7); end
      7'h37: begin c.imm = 4'b1000; c.aluop = 2'b10; c.lui = 1'b1; end
      7'h17: begin c.imm = 4'b1000; c.asel = 1'b1; end
      7'h6f: begin c.imm = 4'b0100; c.asel = 1'b1; c.aluop = 2'b00; end
      7'h67: c.aluop = 2'b00;
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    return (sz == 2'd0) ? 4'b0001 : (sz == 2'd1) ? 4'b0011 : (sz == 2'd2) ? 4'b1111 : 4'b0000;
  endfunction

  // One cycle: drive inputs, compare mid-cycle, advance past the next rising edge
  task automatic cyc(input string nm, input exp_t e, input logic [31:0] ins,
                     input logic beq, input logic blt, input logic rdy);
    exp_t a;
    instr = ins; BrEQ = beq; BrLT = blt; i_mem_ready = rdy;
    #3;
    a = sample();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
    if (o_pc_en) pcen_cnt++;
    if (RegWen) regwen_cnt++;
    if (MemRW) memrw_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic trap_cycles(input string nm, input logic [31:0] ins, inout int n);
    exp_t e;
    e = '0; e.ill = 1'b1; e.st = 3'd7;
    repeat (4) begin cyc({nm, "/trap"}, e, ins, 1'b0, 1'b0, 1'b1); n++; end
  endtask

  task automatic run(input string nm, input logic [31:0] ins, input logic beq, input logic blt,
                     input int dly, input int abort_at, output int n);
    exp_t c, e;
    logic [6:0] opc;
    logic ld, st, br, jmp, ok, tk, rdy;
    opc = ins[6:0];
    ld  = (opc == 7'h03);
    st  = (opc == 7'h23);
    br  = (opc == 7'h63);
    jmp = (opc == 7'h6f) || (opc == 7'h67);
    ok  = opc inside {7'h03, 7'h23, 7'h63, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67};
    c = datapath_ctrl(ins);
    n = 0;
    rdy = 1'b0;
    e = '0;
    cyc({nm, "/fetch"}, e, ins, beq, blt, 1'b0); n++;
    e.st = 3'd1;
    cyc({nm, "/decode"}, e, ins, beq, blt, 1'b0); n++;
    if (!ok) begin trap_cycles(nm, ins, n); return; end
    e = c; e.st = 3'd2;
    if (br) begin
      case (ins[14:12])
        3'd0: tk = beq;
        3'd1: tk = !beq;
        3'd4, 3'd6: tk = blt;
        3'd5, 3'd7: tk = !blt;
        default: tk = 1'b0;
      endcase
      e.pc_en = 1'b1; e.pcsel = tk;
      cyc({nm, "/exec"}, e, ins, beq, blt, 1'b0); n++;
      return;
    end
    cyc({nm, "/exec"}, e, ins, beq, blt, 1'b0); n++;
    if (ld || st) begin
      e = c; e.st = 3'd3; e.memrw = st;
      e.ltype = size_mask(ins[13:12]); e.lsigned = ld & !ins[14];
      for (int k = 0; k < WAIT_MAX; k++) begin
        if (k == abort_at) return;
        rdy = (k >= dly);
        e.pc_en = st & rdy;
        cyc({nm, "/mem"}, e, ins, beq, blt, rdy); n++;
        if (rdy) break;
      end
      if (!rdy) begin trap_cycles(nm, ins, n); return; end
      if (st) return;
    end
    e = c; e.st = 3'd4; e.regwen = 1'b1; e.pc_en = 1'b1; e.pcsel = jmp;
    e.wbsel = ld ? 2'b00 : (jmp ? 2'b10 : 2'b01);
    if (ld) begin e.ltype = size_mask(ins[13:12]); e.lsigned = !ins[14]; end
    cyc({nm, "/wb"}, e, ins, beq, blt, 1'b0); n++;
  endtask

  task automatic row(input string nm, input logic [31:0] ins, input logic beq, input logic blt,
                     input int dly, input int len, input int rw, input int mw);
    int n, pc0, rw0, mw0;
    pc0 = pcen_cnt; rw0 = regwen_cnt; mw0 = memrw_cnt;
    run(nm, ins, beq, blt, dly, -1, n);
    chk({nm, "_len"}, n, len);
    chk({nm, "_pcen"}, pcen_cnt - pc0, 1);
    chk({nm, "_regwen"}, regwen_cnt - rw0, rw);
    chk({nm, "_memrw"}, memrw_cnt - mw0, mw);
  endtask

  task automatic do_reset(input string nm);
    i_reset = 1'b0;
    #1;
    chk({nm, "_state"}, o_state, 0);
    chk({nm, "_outs"}, sample(), 0);
    @(posedge clk); #1;
    i_reset = 1'b1;
  endtask

  initial begin
    int n, pc0, rw0, mw0;
    i_reset = 1'b1; instr = 32'h0; BrEQ = 1'b0; BrLT = 1'b0; i_mem_ready = 1'b0;
    #2 i_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", o_state, 0);
    chk("rst_outs", sample(), 0);
    i_reset = 1'b1;

    //   name       instr          beq   blt   dly len rw mw
    row("addi",   32'h00A00093, 1'b0, 1'b0, 0, 4, 1, 0);
    row("sh",     32'h00E61023, 1'b0, 1'b0, 3, 7, 0, 4);
    row("lh",     32'h00061783, 1'b0, 1'b0, 3, 8, 1, 0);
    row("beq_t",  32'h00208463, 1'b1, 1'b0, 0, 3, 0, 0);
    row("beq_n",  32'h00208463, 1'b0, 1'b0, 0, 3, 0, 0);
    row("bne_t",  32'h00209463, 1'b0, 1'b0, 0, 3, 0, 0);
    row("bltu_t", 32'h0020E463, 1'b0, 1'b1, 0, 3, 0, 0);
    row("bge_n",  32'h0020D463, 1'b0, 1'b1, 0, 3, 0, 0);
    row("lui",    32'h123452B7, 1'b0, 1'b0, 0, 4, 1, 0);
    row("auipc",  32'h00001317, 1'b0, 1'b0, 0, 4, 1, 0);
    row("jal",    32'h010000EF, 1'b0, 1'b0, 0, 4, 1, 0);
    row("jalr",   32'h00008067, 1'b0, 1'b0, 0, 4, 1, 0);
    row("add",    32'h002081B3, 1'b0, 1'b0, 0, 4, 1, 0);
    row("lw",     32'h00402203, 1'b0, 1'b0, 0, 5, 1, 0);
    row("lbu",    32'h00404203, 1'b0, 1'b0, 1, 6, 1, 0);
    row("sb",     32'h00E60023, 1'b0, 1'b0, 0, 4, 0, 1);

    pc0 = pcen_cnt; rw0 = regwen_cnt; mw0 = memrw_cnt;
    run("illegal", 32'h0000007F, 1'b0, 1'b0, 0, -1, n);
    chk("illegal_len", n, 6);
    chk("illegal_flag", o_illegal, 1);
    chk("illegal_strobes", (pcen_cnt - pc0) + (regwen_cnt - rw0) + (memrw_cnt - mw0), 0);
    do_reset("illegal_clr");
    chk("illegal_clr_flag", o_illegal, 0);

    run("lw_timeout", 32'h00402203, 1'b0, 1'b0, 100, -1, n);
    chk("timeout_len", n, 3 + 15 + 4);
    chk("timeout_state", o_state, 7);
    do_reset("timeout_clr");

    run("sh_abort", 32'h00E61023, 1'b0, 1'b0, 100, 2, n);
    chk("abort_memrw_before", MemRW, 1);
    i_reset = 1'b0;
    #1;
    chk("abort_memrw", MemRW, 0);
    chk("abort_state", o_state, 0);
    chk("abort_pcen", o_pc_en, 0);
    @(posedge clk); #1;
    i_reset = 1'b1;
    row("nop", 32'h00000013, 1'b0, 1'b0, 0, 4, 1, 0);

`ifdef CTRL_PERF_CNT_EN
    do_reset("perf_rst");
    repeat (10) run("perf_addi", 32'h00A00093, 1'b0, 1'b0, 0, -1, n);
    chk("perf_instret", o_instret, 10);
    chk("perf_cycle", o_cycle, 40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
